apb_pcie_csr: RTL and testbench

//  APB slave CSR bank for the PCIe subsystem; successor of the single-response PCIe APB block.

---
 rtl/apb_pcie_csr.sv | 169 ++++++++++++++++
 tb/tb_apb_pcie_csr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pcie_csr.sv
// APB CSR bank for the PCIe subsystem: ID, W1C interrupt pending and CHN saturating event channels.
// Build macro APB_PCIE_CSR_RDCLR_EN makes a COUNT read clear that counter at the response edge.
module apb_pcie_csr #(
    parameter int          CHN       = 4,
    parameter int          CNT_WIDTH = 16,
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] ID_VALUE  = 32'hC1E0_0001
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_psel,
    input  logic                 i_penable,
    input  logic                 i_pwrite,
    input  logic [ADDR_BITS-1:0] i_paddr,
    input  logic [31:0]          i_pwdata,
    output logic [31:0]          o_prdata,
    output logic                 o_pready,
    output logic                 o_pslverr,
    input  logic [CHN-1:0]       i_ev,
    output logic                 o_irq
);
    localparam int BLK_W = ADDR_BITS - 4;

    logic                 resp_valid;
    logic                 resp_err;
    logic [31:0]          resp_rdata;
    logic                 access;
    logic [BLK_W-1:0]     blk;
    logic [1:0]           sel;

    logic [CHN-1:0]       en;
    logic [CHN-1:0]       irq_en;
    logic [CHN-1:0]       pending;
    logic [CHN-1:0]       inc;
    logic [CNT_WIDTH-1:0] cnt     [CHN];
    logic [CNT_WIDTH-1:0] thresh  [CHN];
    logic [CNT_WIDTH-1:0] cnt_nxt [CHN];

    logic [CHN-1:0]       wr_ctrl;
    logic [CHN-1:0]       wr_thresh;
    logic [CHN-1:0]       clr_req;
    logic [CHN-1:0]       rdclr_req;
    logic [CHN-1:0]       w1c_mask;
    logic [CHN-1:0]       irq_set;
    logic [31:0]          dec_rdata;
    logic                 dec_err;
    logic                 unused_bits;

    // APB handshake: a transfer is accepted on the first edge that sees psel&penable with no
    // response held; pready is then high for exactly one cycle while the master still holds
    // psel&penable, and resp_valid blocks a second acceptance of the same transfer.
    assign access      = i_psel & i_penable & ~resp_valid;
    assign blk         = i_paddr[ADDR_BITS-1:4];
    assign sel         = i_paddr[3:2];
    assign inc         = en & i_ev;
    assign o_pready    = resp_valid;
    assign o_prdata    = resp_rdata;
    assign o_pslverr   = resp_err;
    assign unused_bits = ^{i_paddr[1:0], i_pwdata};

    // Address decode; anything not explicitly matched stays an error with zero read data.
    always_comb begin
        dec_rdata = '0;
        dec_err   = 1'b1;
        wr_ctrl   = '0;
        wr_thresh = '0;
        clr_req   = '0;
        rdclr_req = '0;
        w1c_mask  = '0;
        if (blk == '0) begin
            case (sel)
                2'd0: begin
                    dec_err = i_pwrite;
                    if (!i_pwrite) dec_rdata = ID_VALUE;
                end
                2'd1: begin
                    dec_err = 1'b0;
                    if (i_pwrite) w1c_mask = i_pwdata[CHN-1:0];
                    else          dec_rdata[CHN-1:0] = pending;
                end
                default: ;
            endcase
        end
        for (int n = 0; n < CHN; n++) begin
            if (blk == BLK_W'(n + 1)) begin
                case (sel)
                    2'd0: begin
                        dec_err = 1'b0;
                        if (i_pwrite) begin
                            wr_ctrl[n] = 1'b1;
                            clr_req[n] = i_pwdata[2];
                        end else begin
                            dec_rdata[1:0] = {irq_en[n], en[n]};
                        end
                    end
                    2'd1: begin
                        if (!i_pwrite) begin
                            dec_err                  = 1'b0;
                            dec_rdata[CNT_WIDTH-1:0] = cnt[n];
`ifdef APB_PCIE_CSR_RDCLR_EN
                            rdclr_req[n]             = 1'b1;
`endif
                        end
                    end
                    2'd2: begin
                        dec_err = 1'b0;
                        if (i_pwrite) wr_thresh[n] = 1'b1;
                        else          dec_rdata[CNT_WIDTH-1:0] = thresh[n];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Counter next-state: explicit clear beats events; an IRQ only fires on a counted increment.
    always_comb begin
        logic counted;
        counted = 1'b0;
        irq_set = '0;
        for (int n = 0; n < CHN; n++) begin
            counted    = 1'b0;
            cnt_nxt[n] = cnt[n];
            if (access && clr_req[n]) begin
                cnt_nxt[n] = '0;
            end else if (access && rdclr_req[n]) begin
                cnt_nxt[n] = inc[n] ? CNT_WIDTH'(1) : '0;
                counted    = inc[n];
            end else if (inc[n] && (cnt[n] != '1)) begin
                cnt_nxt[n] = cnt[n] + 1'b1;
                counted    = 1'b1;
            end
            irq_set[n] = counted && irq_en[n] && (thresh[n] != '0) && (cnt_nxt[n] == thresh[n]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            en         <= '0;
            irq_en     <= '0;
            pending    <= '0;
            o_irq      <= 1'b0;
            for (int n = 0; n < CHN; n++) begin
                cnt[n]    <= '0;
                thresh[n] <= '0;
            end
        end else begin
            resp_valid <= access;
            if (access) begin
                resp_rdata <= dec_rdata;
                resp_err   <= dec_err;
            end
            for (int n = 0; n < CHN; n++) begin
                cnt[n] <= cnt_nxt[n];
                if (access && wr_ctrl[n]) begin
                    en[n]     <= i_pwdata[0];
                    irq_en[n] <= i_pwdata[1];
                end
                if (access && wr_thresh[n]) thresh[n] <= i_pwdata[CNT_WIDTH-1:0];
            end
            // Hardware set wins over a simultaneous W1C of the same bit.
            pending <= (pending & ~(access ? w1c_mask : '0)) | irq_set;
            o_irq   <= |pending;
        end
    end
endmodule

// File: tb/tb_apb_pcie_csr.sv
// Directed bench for apb_pcie_csr: a 16-bit counter instance plus a 4-bit one for saturation.
module tb_apb_pcie_csr;
    localparam int CHN = 4;

    logic           clk, rst, psel, penable, pwrite;
    logic [11:0]    paddr;
    logic [31:0]    pwdata;
    logic [31:0]    prdata, prdata4;
    logic           pready, pready4, pslverr, pslverr4, irq, irq4;
    logic [CHN-1:0] ev, ev4;

    int             n_cmp, n_fail;
    logic [31:0]    exp_q[$];
    logic [31:0]    t_rd, t_rd4;
    logic           t_err;
    int             t_lat;

    apb_pcie_csr #(.CHN(CHN), .CNT_WIDTH(16), .ADDR_BITS(12), .ID_VALUE(32'hC1E0_0001)) dut (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
        .o_pslverr(pslverr), .i_ev(ev), .o_irq(irq)
    );

    apb_pcie_csr #(.CHN(CHN), .CNT_WIDTH(4), .ADDR_BITS(12), .ID_VALUE(32'hC1E0_0001)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata4), .o_pready(pready4),
        .o_pslverr(pslverr4), .i_ev(ev4), .o_irq(irq4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: one APB transfer; evm pulses i_ev for the cycle ending at the acceptance edge
    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [CHN-1:0] evm, output logic [31:0] rd, output logic err,
                       output logic [31:0] rd4, output int lat);
        lat = 0; rd = '0; err = 1'b0; rd4 = '0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1; ev = evm; lat = 1;
        do begin
            @(posedge clk); #1;
            lat++;
            ev = '0;
        end while (!pready && lat < 8);
        if (!pready) begin
            n_cmp++; n_fail++;
            $display("FAIL apb_timeout addr=%h pready got 0 want 1", addr);
        end else begin
            rd = prdata; err = pslverr; rd4 = prdata4;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_wr(input logic [11:0] a, input logic [31:0] d, input logic [CHN-1:0] evm);
        apb(1'b1, a, d, evm, t_rd, t_err, t_rd4, t_lat);
    endtask

    task automatic do_rd(input logic [11:0] a, input logic [CHN-1:0] evm);
        apb(1'b0, a, 32'h0, evm, t_rd, t_err, t_rd4, t_lat);
    endtask

    task automatic pulse(input logic [CHN-1:0] m, input logic [CHN-1:0] m4, input int times);
        for (int i = 0; i < times; i++) begin
            @(posedge clk); #1; ev = m; ev4 = m4;
            @(posedge clk); #1; ev = '0; ev4 = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rst_prdata got %h want 0", prdata); end
        n_cmp++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rst_pready got %b want 0", pready); end
        n_cmp++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr got %b want 0", pslverr); end
        n_cmp++; if (irq !== 1'b0 || irq4 !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b/%b want 0/0", irq, irq4); end
        rst = 1'b0;
    endtask

    task automatic test_id_read();
        do_rd(12'h000, '0);
        n_cmp++; if (t_lat !== 2) begin n_fail++; $display("FAIL id_latency got %0d want 2", t_lat); end
        n_cmp++; if (t_rd !== 32'hC1E0_0001) begin n_fail++; $display("FAIL id_value got %h want c1e00001", t_rd); end
        n_cmp++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL id_err got %b want 0", t_err); end
    endtask

    task automatic test_errors();
        do_wr(12'h010, 32'h1, '0);
        pulse(4'h1, 4'h0, 1);
        do_rd(12'h0F0, '0);
        n_cmp++; if (t_err !== 1'b1 || t_rd !== 32'h0) begin n_fail++; $display("FAIL err_ch14 got err=%b rd=%h want 1/0", t_err, t_rd); end
        n_cmp++; if (t_lat !== 2) begin n_fail++; $display("FAIL err_latency got %0d want 2", t_lat); end
        do_wr(12'h014, 32'hAB, '0);
        n_cmp++; if (t_err !== 1'b1 || t_rd !== 32'h0) begin n_fail++; $display("FAIL err_wr_count got err=%b rd=%h want 1/0", t_err, t_rd); end
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h1 || t_err !== 1'b0) begin n_fail++; $display("FAIL count_kept got %h err=%b want 1/0", t_rd, t_err); end
        do_wr(12'h000, 32'h0, '0);
        n_cmp++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL err_wr_id got %b want 1", t_err); end
        do_rd(12'h008, '0);
        n_cmp++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL err_0x008 got %b want 1", t_err); end
        do_rd(12'h050, '0);
        n_cmp++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL err_ch4 got %b want 1", t_err); end
        do_rd(12'h04C, '0);
        n_cmp++; if (t_err !== 1'b1 || t_rd !== 32'h0) begin n_fail++; $display("FAIL err_0x04c got err=%b rd=%h want 1/0", t_err, t_rd); end
    endtask

    task automatic test_ctrl_rw();
        do_wr(12'h020, 32'h7, '0);
        do_rd(12'h020, '0);
        n_cmp++; if (t_rd !== 32'h3 || t_rd4 !== 32'h3) begin n_fail++; $display("FAIL ctrl_rd got %h/%h want 3/3", t_rd, t_rd4); end
        do_wr(12'h028, 32'hFFFF_1234, '0);
        do_rd(12'h028, '0);
        n_cmp++; if (t_rd !== 32'h1234) begin n_fail++; $display("FAIL thresh16 got %h want 1234", t_rd); end
        n_cmp++; if (t_rd4 !== 32'h4) begin n_fail++; $display("FAIL thresh4 got %h want 4", t_rd4); end
        do_wr(12'h020, 32'h0, '0);
        do_wr(12'h028, 32'h0, '0);
    endtask

    task automatic test_irq();
        do_wr(12'h010, 32'h4, '0);
        do_wr(12'h018, 32'h3, '0);
        do_wr(12'h010, 32'h3, '0);
        pulse(4'h1, 4'h0, 3);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b want 1", irq); end
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h3) begin n_fail++; $display("FAIL irq_count got %h want 3", t_rd); end
        do_rd(12'h004, '0);
        n_cmp++; if (t_rd !== 32'h1) begin n_fail++; $display("FAIL irq_pending got %h want 1", t_rd); end
        do_wr(12'h004, 32'h1, '0);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got %b want 0", irq); end
        pulse(4'h1, 4'h0, 1);
        do_rd(12'h004, '0);
        n_cmp++; if (t_rd !== 32'h0) begin n_fail++; $display("FAIL irq_past_thresh got %h want 0", t_rd); end
    endtask

    task automatic test_set_wins();
        do_wr(12'h018, 32'h5, '0);
        do_wr(12'h004, 32'h1, 4'h1);
        do_rd(12'h004, '0);
        n_cmp++; if (t_rd !== 32'h1) begin n_fail++; $display("FAIL set_wins got %h want 1", t_rd); end
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h5) begin n_fail++; $display("FAIL set_wins_count got %h want 5", t_rd); end
        do_wr(12'h004, 32'h1, '0);
    endtask

    task automatic test_clr_vs_ev();
        do_wr(12'h010, 32'h7, 4'h1);
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h0) begin n_fail++; $display("FAIL clr_wins got %h want 0", t_rd); end
        do_rd(12'h010, '0);
        n_cmp++; if (t_rd !== 32'h3) begin n_fail++; $display("FAIL clr_ctrl got %h want 3", t_rd); end
    endtask

    task automatic test_thresh_old();
        do_wr(12'h018, 32'h1, 4'h1);
        do_rd(12'h004, '0);
        n_cmp++; if (t_rd !== 32'h0) begin n_fail++; $display("FAIL thresh_old_pending got %h want 0", t_rd); end
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h1) begin n_fail++; $display("FAIL thresh_old_count got %h want 1", t_rd); end
    endtask

    task automatic test_en_clear_ev();
        do_wr(12'h010, 32'h0, 4'h1);
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h2) begin n_fail++; $display("FAIL en_clear_counted got %h want 2", t_rd); end
        pulse(4'h1, 4'h0, 1);
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd !== 32'h2) begin n_fail++; $display("FAIL disabled_count got %h want 2", t_rd); end
    endtask

    task automatic test_saturation();
        do_wr(12'h010, 32'h1, '0);
        pulse(4'h0, 4'h1, 20);
        do_rd(12'h014, '0);
        n_cmp++; if (t_rd4 !== 32'hF) begin n_fail++; $display("FAIL saturate got %h want f", t_rd4); end
        n_cmp++; if (t_rd !== 32'h2) begin n_fail++; $display("FAIL sat_other_dut got %h want 2", t_rd); end
    endtask

    task automatic test_count_read();
        do_wr(12'h010, 32'h5, '0);
        pulse(4'h1, 4'h0, 5);
        do_rd(12'h014, 4'h1);
        n_cmp++; if (t_rd !== 32'h5) begin n_fail++; $display("FAIL count_read got %h want 5", t_rd); end
        do_rd(12'h014, '0);
`ifdef APB_PCIE_CSR_RDCLR_EN
        n_cmp++; if (t_rd !== 32'h1) begin n_fail++; $display("FAIL rdclr_after got %h want 1", t_rd); end
`else
        n_cmp++; if (t_rd !== 32'h6) begin n_fail++; $display("FAIL read_no_clear got %h want 6", t_rd); end
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pready got %b want 0", pready); end
        n_cmp++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_prdata got %h want 0", prdata); end
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got %b want 0", pready); end
        do_rd(12'h018, '0);
        n_cmp++; if (t_rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_thresh got %h want 0", t_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, e;
        for (int n = 0; n < CHN; n++) begin
            v = 32'hA5A5_0000 | (32'(n) * 32'h111 + 32'h1);
            do_wr(12'h018 + 12'(16 * n), v, '0);
            exp_q.push_back(v & 32'h0000_FFFF);
        end
        for (int n = 0; n < CHN; n++) begin
            do_rd(12'h018 + 12'(16 * n), '0);
            e = exp_q.pop_front();
            n_cmp++; if (t_rd !== e || t_err !== 1'b0) begin n_fail++; $display("FAIL b2b_thresh%0d got %h err=%b want %h/0", n, t_rd, t_err, e); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ev = '0; ev4 = '0;
        test_reset();
        test_id_read();
        test_errors();
        test_ctrl_rw();
        test_irq();
        test_set_wins();
        test_clr_vs_ev();
        test_thresh_old();
        test_en_clear_ev();
        test_saturation();
        test_count_read();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
